mesh_traffic_source: RTL and testbench
======================================

MESH_TRAFFIC_SOURCE -- requirements
Module: mesh_traffic_source

Interface
REQ-001 Parameter ROWS, default 4: number of mesh rows.
REQ-002 Parameter COLUMS, default 4: number of mesh columns.
REQ-003 Parameter PCKG_SZ, default 40: packet width in bits; minimum 24.
REQ-004 Parameter FIFO_DEPTH, default 4: entries per terminal FIFO.
REQ-005 Derived constant N = 2*ROWS+2*COLUMS: number of edge terminals (16 by default).
REQ-006 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-007 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port start, input, 1 bit: one-cycle request to begin a run; honoured only in IDLE.
REQ-009 Port num_pkts, input, 16 bits: number of packets to generate per run; sampled on start.
REQ-010 Port seed, input, 32 bits: LFSR seed; sampled on start.
REQ-011 Port popin, input, N bits: bit t set pops the head of terminal t's FIFO.
REQ-012 Port pndng_i_in, output, N bits: bit t set while terminal t's FIFO is non-empty.
REQ-013 Port data_out_i_in, output, N x PCKG_SZ bits: head entry of each terminal FIFO (show-ahead).
REQ-014 Port busy, output, 1 bit: high while in RUN.
REQ-015 Port done, output, 1 bit: high while in DONE.
REQ-016 Port sent_count, output, 16 bits: number of packets enqueued in the current or last run.

Function
REQ-017 Packet format, MSB first: Nxt_jump[7:0] = 0, dst_row[3:0], dst_col[3:0], mode[0], payload[PCKG_SZ-18:0].
REQ-018 Terminal addressing is fixed:
- t in 0..C-1: row 0, col t+1.
- t in C..C+R-1: row t-C+1, col 0.
- t in C+R..2C+R-1: row R+1, col t-C-R+1.
- t in 2C+R..N-1: row t-2C-R+1, col C+1.
REQ-019 Generator is a 32-bit Galois LFSR with taps x^32+x^22+x^2+x+1; a zero seed is replaced by 32'hACE1.
REQ-020 State machine IDLE -> RUN on start; RUN -> DONE when sent_count equals num_pkts; DONE -> RUN on start.
REQ-021 start with num_pkts = 0 goes to DONE on the next cycle without enqueuing.
REQ-022 In RUN, each cycle forms a candidate packet from the current LFSR value:
- src = lfsr[7:0] mod N.
- dst = lfsr[15:8] mod N; if dst equals src, dst = (src+1) mod N.
- mode = lfsr[16].
- payload = low bits of {lfsr[31:17], lfsr[15:0]}, truncated to the payload width.
REQ-023 The candidate is pushed into FIFO src when that FIFO is not full; the LFSR then advances and sent_count increments in the same cycle.
REQ-024 When FIFO src is full, the candidate and the LFSR hold; this repeats until space frees, giving a stall of 1+ cycles.
REQ-025 At most one push per cycle; packet latency is one cycle from push to pndng_i_in.
REQ-026 Each terminal FIFO is FIFO_DEPTH deep and show-ahead.
- A pop on an empty FIFO is ignored.
- A simultaneous push and pop is legal when the FIFO is not full.
- When full, a push is refused even if a pop occurs in the same cycle.
REQ-027 Pointers wrap modulo FIFO_DEPTH; an occupancy counter of width clog2(FIFO_DEPTH+1) determines full and empty.
REQ-028 start asserted in RUN is ignored; FIFOs keep draining in every state.

Reset
REQ-029 Asserting reset forces the following immediately, including mid-run; in-flight packets are discarded:
- State IDLE.
- All FIFOs empty.
- pndng_i_in = 0 and data_out_i_in = 0.
- busy = 0, done = 0, sent_count = 0.
- LFSR = 32'hACE1.
REQ-030 Reset deassertion has no other side effect; the block stays in IDLE until start.

Structure
REQ-031 A shared package holds:
- The packet field widths and offsets.
- The FSM state enum (IDLE, RUN, DONE).
- The terminal-to-(row,col) mapping function.
- The LFSR next-state function.
REQ-032 One sub-module, terminal_fifo, is instantiated N times; the FSM, LFSR and dispatch logic stay in the top level.

Verification
REQ-033 Reset is asserted for 5 cycles, then released -> all outputs are 0 and the state is IDLE.
REQ-034 num_pkts=1, seed=32'h1, no pops -> exactly one pndng_i_in bit is set, the packet matches the reference-model fields, sent_count=1, and done rises.
REQ-035 num_pkts=5 with popin held at 0 and a seed that forces the same src -> 4 pushes, then busy stays high with sent_count=4; releasing one pop completes the run.
REQ-036 num_pkts=200, random pops -> each packet has dst != src, a legal terminal (row,col) and Nxt_jump=0, and total pops equal 200.
REQ-037 Reset asserted mid-run at sent_count=50 -> all FIFOs empty asynchronously; the next start with the same seed reproduces the identical packet sequence.
REQ-038 Pop and push on the same FIFO with occupancy 3 -> occupancy stays 3; a pop on an empty FIFO leaves pndng_i_in bit t at 0.

Source files
------------

// File: rtl/mesh_traffic_source_pkg.sv
// Shared definitions for the mesh edge traffic source: packet layout,
// run-control states, terminal coordinates and the pseudo-random generator.
package mesh_traffic_source_pkg;

  localparam int NXT_JUMP_W = 8;
  localparam int ROW_W      = 4;
  localparam int COL_W      = 4;
  localparam int MODE_W     = 1;
  localparam int HDR_W      = NXT_JUMP_W + ROW_W + COL_W + MODE_W;

  localparam logic [31:0] LFSR_RESET = 32'h0000_ACE1;
  // Feedback terms x^22 + x^2 + x + 1 of the left-shifting Galois form
  localparam logic [31:0] LFSR_MASK  = 32'h0040_0007;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Field positions counted from bit 0 of a packet of the given width
  function automatic int payload_w(input int pckg_sz);
    return pckg_sz - HDR_W;
  endfunction

  function automatic int mode_pos(input int pckg_sz);
    return pckg_sz - HDR_W;
  endfunction

  function automatic int col_pos(input int pckg_sz);
    return mode_pos(pckg_sz) + MODE_W;
  endfunction

  function automatic int row_pos(input int pckg_sz);
    return col_pos(pckg_sz) + COL_W;
  endfunction

  function automatic int nxt_jump_pos(input int pckg_sz);
    return row_pos(pckg_sz) + ROW_W;
  endfunction

  function automatic logic [31:0] lfsr_next(input logic [31:0] v);
    return {v[30:0], 1'b0} ^ (v[31] ? LFSR_MASK : 32'h0000_0000);
  endfunction

  // Returns {row, col} of edge terminal t: top, left, bottom, then right edge
  function automatic logic [7:0] term_rowcol(input int t, input int rows, input int cols);
    int r;
    int c;
    if (t < cols) begin
      r = 0;
      c = t + 1;
    end else if (t < cols + rows) begin
      r = t - cols + 1;
      c = 0;
    end else if (t < 2 * cols + rows) begin
      r = rows + 1;
      c = t - cols - rows + 1;
    end else begin
      r = t - 2 * cols - rows + 1;
      c = cols + 1;
    end
    return {r[3:0], c[3:0]};
  endfunction

endpackage

// File: rtl/mesh_traffic_source_terminal_fifo.sv
// Show-ahead FIFO for one edge terminal; a full FIFO refuses a push even
// when it is popped in the same cycle.
module terminal_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 40
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         pndng,
  output logic         full,
  output logic [W-1:0] data_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CNT_MAX);
  assign pndng     = (count_r != {CNT_W{1'b0}});
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & pndng;
  assign data_out  = mem_r[rd_ptr_r];

  // Storage, wrapping pointers and occupancy count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r <= (wr_ptr_r == PTR_LAST) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/mesh_traffic_source.sv
// Pseudo-random packet source feeding one FIFO per mesh edge terminal;
// a run enqueues num_pkts packets, stalling whenever the chosen FIFO is full.
module mesh_traffic_source
  import mesh_traffic_source_pkg::*;
#(
  parameter  int ROWS       = 4,
  parameter  int COLUMS     = 4,
  parameter  int PCKG_SZ    = 40,
  parameter  int FIFO_DEPTH = 4,
  localparam int N          = 2 * ROWS + 2 * COLUMS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [15:0]          num_pkts,
  input  logic [31:0]          seed,
  input  logic [N-1:0]         popin,
  output logic [N-1:0]         pndng_i_in,
  output logic [N*PCKG_SZ-1:0] data_out_i_in,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          sent_count
);

  localparam int PW = payload_w(PCKG_SZ);
  localparam int TW = (N > 1) ? $clog2(N) : 1;
  localparam logic [7:0]    N8     = 8'(N);
  localparam logic [TW-1:0] T_LAST = TW'(N - 1);

  state_e              state_r;
  state_e              state_nxt_s;
  logic [31:0]         lfsr_r;
  logic [31:0]         seed_s;
  logic [15:0]         num_r;
  logic [15:0]         sent_r;
  logic [TW-1:0]       src_s;
  logic [TW-1:0]       dst_raw_s;
  logic [TW-1:0]       dst_s;
  logic [7:0]          rowcol_s;
  logic [PW-1:0]       payload_s;
  logic [PCKG_SZ-1:0]  pkt_s;
  logic                push_s;
  logic                accept_start_s;
  logic [N-1:0]        fifo_full_s;
  logic [N-1:0]        push_vec_s;

  assign seed_s         = (seed == 32'h0000_0000) ? LFSR_RESET : seed;
  assign accept_start_s = start && (state_r != RUN);

  // Candidate packet drawn from the current generator value
  assign src_s     = TW'(lfsr_r[7:0] % N8);
  assign dst_raw_s = TW'(lfsr_r[15:8] % N8);
  assign dst_s     = (dst_raw_s != src_s) ? dst_raw_s :
                     ((src_s == T_LAST) ? {TW{1'b0}} : src_s + TW'(1));
  assign rowcol_s  = term_rowcol(int'(dst_s), ROWS, COLUMS);
  assign payload_s = PW'({lfsr_r[31:17], lfsr_r[15:0]});
  assign pkt_s     = {8'h00, rowcol_s, lfsr_r[16], payload_s};

  assign push_s = (state_r == RUN) && (sent_r != num_r) && !fifo_full_s[src_s];

  assign busy       = (state_r == RUN);
  assign done       = (state_r == DONE);
  assign sent_count = sent_r;

  // Run-control next state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_nxt_s = (num_pkts == 16'd0) ? DONE : RUN;
        end else begin
          state_nxt_s = state_r;
        end
      end
      RUN: begin
        if (sent_r == num_r) begin
          state_nxt_s = DONE;
        end else if (push_s && ((sent_r + 16'd1) == num_r)) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // One-hot push strobe towards the selected terminal
  always_comb begin
    push_vec_s = {N{1'b0}};
    if (push_s) begin
      push_vec_s[src_s] = 1'b1;
    end else begin
      push_vec_s = {N{1'b0}};
    end
  end

  // Run-control state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Generator, run length and packet counter; a stalled candidate holds the generator
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_r <= LFSR_RESET;
      num_r  <= 16'd0;
      sent_r <= 16'd0;
    end else if (accept_start_s) begin
      lfsr_r <= seed_s;
      num_r  <= num_pkts;
      sent_r <= 16'd0;
    end else if (push_s) begin
      lfsr_r <= lfsr_next(lfsr_r);
      sent_r <= sent_r + 16'd1;
    end else begin
      lfsr_r <= lfsr_r;
    end
  end

  for (genvar t = 0; t < N; t++) begin : g_term
    terminal_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (PCKG_SZ)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_vec_s[t]),
      .push_data (pkt_s),
      .pop       (popin[t]),
      .pndng     (pndng_i_in[t]),
      .full      (fifo_full_s[t]),
      .data_out  (data_out_i_in[t*PCKG_SZ +: PCKG_SZ])
    );
  end

endmodule

// File: tb/tb_mesh_traffic_source.sv
// Scoreboard bench for mesh_traffic_source: expected packets are generated
// from a reference model at start and matched against terminal pops.
module tb_mesh_traffic_source;

  localparam int N  = 16;
  localparam int PS = 40;

  logic            clk;
  logic            reset;
  logic            start;
  logic [15:0]     num_pkts;
  logic [31:0]     seed;
  logic [N-1:0]    popin;
  logic [N-1:0]    pndng_i_in;
  logic [N*PS-1:0] data_out_i_in;
  logic            busy;
  logic            done;
  logic [15:0]     sent_count;

  typedef struct {
    int          term;
    logic [39:0] pkt;
  } sb_t;

  sb_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  pops   = 0;

  mesh_traffic_source #(
    .ROWS       (4),
    .COLUMS     (4),
    .PCKG_SZ    (PS),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .num_pkts      (num_pkts),
    .seed          (seed),
    .popin         (popin),
    .pndng_i_in    (pndng_i_in),
    .data_out_i_in (data_out_i_in),
    .busy          (busy),
    .done          (done),
    .sent_count    (sent_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  function automatic logic [31:0] m_next(input logic [31:0] v);
    return {v[30:0], 1'b0} ^ (v[31] ? 32'h0040_0007 : 32'h0000_0000);
  endfunction

  function automatic logic [7:0] m_rc(input int t);
    int r;
    int c;
    if (t < 4) begin r = 0; c = t + 1; end
    else if (t < 8) begin r = t - 3; c = 0; end
    else if (t < 12) begin r = 5; c = t - 7; end
    else begin r = t - 11; c = 5; end
    return {r[3:0], c[3:0]};
  endfunction

  function automatic bit legal_rc(input logic [7:0] rc);
    int r;
    int c;
    r = int'(rc[7:4]);
    c = int'(rc[3:0]);
    return ((r == 0 || r == 5) && c >= 1 && c <= 4) || ((c == 0 || c == 5) && r >= 1 && r <= 4);
  endfunction

  function automatic void m_pkt(input logic [31:0] v, output int src, output logic [39:0] pkt);
    int          dst;
    logic [30:0] pl;
    src = int'(v[7:0]) % N;
    dst = int'(v[15:8]) % N;
    if (dst == src) dst = (src + 1) % N;
    pl  = {v[31:17], v[15:0]};
    pkt = {8'h00, m_rc(dst), v[16], pl[22:0]};
  endfunction

  task automatic start_run(input logic [31:0] s, input int n);
    logic [31:0] v;
    int          src;
    logic [39:0] p;
    sb_t         e;
    v = (s == 32'h0) ? 32'h0000_ACE1 : s;
    for (int k = 0; k < n; k++) begin
      m_pkt(v, src, p);
      e.term = src;
      e.pkt  = p;
      sb.push_back(e);
      v = m_next(v);
    end
    start    = 1'b1;
    num_pkts = 16'(n);
    seed     = s;
    @(negedge clk);
    start    = 1'b0;
  endtask

  task automatic pop_cycle(input logic [N-1:0] mask, input bit chk);
    logic [39:0] got;
    int          idx;
    for (int t = 0; t < N; t++) begin
      if (mask[t] && pndng_i_in[t]) begin
        got = data_out_i_in[t*PS +: PS];
        idx = -1;
        for (int i = 0; i < sb.size(); i++) if (idx < 0 && sb[i].term == t) idx = i;
        checks++;
        if (idx < 0) begin
          errors++;
          $display("FAIL sb_unexpected: terminal %0d got %h, required no packet", t, got);
        end else begin
          if (got !== sb[idx].pkt) begin
            errors++;
            $display("FAIL pkt_data: terminal %0d got %h, required %h", t, got, sb[idx].pkt);
          end
          sb.delete(idx);
        end
        if (chk) begin
          checks += 3;
          if (got[39:32] !== 8'h00) begin
            errors++;
            $display("FAIL nxt_jump: terminal %0d got %h, required 00", t, got[39:32]);
          end
          if (got[31:24] === m_rc(t)) begin
            errors++;
            $display("FAIL dst_ne_src: terminal %0d got dst %h, required != %h", t, got[31:24], m_rc(t));
          end
          if (!legal_rc(got[31:24])) begin
            errors++;
            $display("FAIL dst_legal: terminal %0d got dst %h, required edge terminal", t, got[31:24]);
          end
        end
        pops++;
      end
    end
    popin = mask & pndng_i_in;
    @(negedge clk);
    popin = '0;
  endtask

  task automatic drain(input int max_cyc, input bit rnd, input bit chk);
    int cyc;
    cyc = 0;
    while (!(done && pndng_i_in == '0) && cyc < max_cyc) begin
      pop_cycle(rnd ? N'($urandom) : '1, chk);
      cyc++;
    end
    checks += 2;
    if (cyc >= max_cyc) begin
      errors++;
      $display("FAIL drain_timeout: got %0d cycles, required < %0d", cyc, max_cyc);
    end
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: got %0d packets outstanding, required 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic wait_done(input int max_cyc);
    int cyc;
    cyc = 0;
    while (!done && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: got done %b, required 1", done);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 1'b0; num_pkts = 16'd0; seed = 32'h0; popin = '0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks += 5;
    if (pndng_i_in !== '0) begin errors++; $display("FAIL rst_pndng: got %h, required 0", pndng_i_in); end
    if (data_out_i_in !== '0) begin errors++; $display("FAIL rst_data: got nonzero, required 0"); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b, required 0", done); end
    if (sent_count !== 16'd0) begin errors++; $display("FAIL rst_sent: got %0d, required 0", sent_count); end
  endtask

  task automatic test_single;
    start_run(32'h1, 1);
    wait_done(20);
    checks += 3;
    if (pndng_i_in !== 16'h0002) begin errors++; $display("FAIL single_pndng: got %h, required 0002", pndng_i_in); end
    if (sent_count !== 16'd1) begin errors++; $display("FAIL single_sent: got %0d, required 1", sent_count); end
    if (data_out_i_in[1*PS +: PS] !== 40'h00_0100_0001) begin
      errors++;
      $display("FAIL single_pkt: got %h, required 0001000001", data_out_i_in[1*PS +: PS]);
    end
    drain(50, 1'b0, 1'b1);
  endtask

  task automatic test_stall;
    start_run(32'h0000_1000, 5);
    repeat (20) @(negedge clk);
    checks += 4;
    if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b, required 1", busy); end
    if (done !== 1'b0) begin errors++; $display("FAIL stall_done: got %b, required 0", done); end
    if (sent_count !== 16'd4) begin errors++; $display("FAIL stall_sent: got %0d, required 4", sent_count); end
    if (pndng_i_in !== 16'h0001) begin errors++; $display("FAIL stall_pndng: got %h, required 0001", pndng_i_in); end
    pop_cycle(16'h0001, 1'b1);
    wait_done(20);
    checks++;
    if (sent_count !== 16'd5) begin errors++; $display("FAIL stall_sent_end: got %0d, required 5", sent_count); end
    drain(50, 1'b0, 1'b1);
  endtask

  task automatic test_random;
    pops = 0;
    start_run(32'hDEAD_BEEF, 200);
    drain(5000, 1'b1, 1'b1);
    checks += 2;
    if (pops != 200) begin errors++; $display("FAIL rand_pops: got %0d, required 200", pops); end
    if (sent_count !== 16'd200) begin errors++; $display("FAIL rand_sent: got %0d, required 200", sent_count); end
  endtask

  task automatic test_reset_midrun;
    int cyc;
    start_run(32'h1234_5678, 200);
    cyc = 0;
    while (sent_count != 16'd50 && cyc < 500) begin
      pop_cycle('1, 1'b0);
      cyc++;
    end
    checks++;
    if (sent_count !== 16'd50) begin errors++; $display("FAIL mid_reach50: got %0d, required 50", sent_count); end
    #2 reset = 1'b0;
    #1;
    checks += 4;
    if (pndng_i_in !== '0) begin errors++; $display("FAIL mid_pndng: got %h, required 0", pndng_i_in); end
    if (data_out_i_in !== '0) begin errors++; $display("FAIL mid_data: got nonzero, required 0"); end
    if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b, required 0", busy); end
    if (sent_count !== 16'd0) begin errors++; $display("FAIL mid_sent: got %0d, required 0", sent_count); end
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    start_run(32'h1234_5678, 60);
    drain(1000, 1'b1, 1'b1);
    checks++;
    if (sent_count !== 16'd60) begin errors++; $display("FAIL mid_rerun_sent: got %0d, required 60", sent_count); end
  endtask

  task automatic test_push_pop;
    int n;
    start_run(32'h0000_1000, 3);
    wait_done(20);
    checks++;
    if (pndng_i_in !== 16'h0001) begin errors++; $display("FAIL pp_pndng: got %h, required 0001", pndng_i_in); end
    start_run(32'h0000_1000, 1);
    pop_cycle(16'h0001, 1'b0);
    n = 0;
    while (pndng_i_in[0] && n < 10) begin
      pop_cycle(16'h0001, 1'b0);
      n++;
    end
    checks += 3;
    if (n != 3) begin errors++; $display("FAIL pp_occupancy: got %0d, required 3", n); end
    if (done !== 1'b1) begin errors++; $display("FAIL pp_done: got %b, required 1", done); end
    if (sb.size() != 0) begin errors++; $display("FAIL pp_sb: got %0d outstanding, required 0", sb.size()); end
    sb.delete();
    popin = 16'h0001;
    repeat (2) @(negedge clk);
    popin = '0;
    checks++;
    if (pndng_i_in[0] !== 1'b0) begin errors++; $display("FAIL empty_pop: got %b, required 0", pndng_i_in[0]); end
  endtask

  task automatic test_zero_pkts;
    start_run(32'h5, 0);
    checks += 3;
    if (done !== 1'b1) begin errors++; $display("FAIL zero_done: got %b, required 1", done); end
    if (sent_count !== 16'd0) begin errors++; $display("FAIL zero_sent: got %0d, required 0", sent_count); end
    if (pndng_i_in !== '0) begin errors++; $display("FAIL zero_pndng: got %h, required 0", pndng_i_in); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_random();
    test_reset_midrun();
    test_push_pop();
    test_zero_pkts();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
